// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the multicycle BIP CPU: opcode values, FSM state
// encoding, ALU operation encoding and the decode helpers used by the top.
// No ports (package).
// -----------------------------------------------------------------------------
package bip_pkg;

   localparam logic [4:0] OP_HLT  = 5'b00000;
   localparam logic [4:0] OP_STO  = 5'b00001;
   localparam logic [4:0] OP_LD   = 5'b00010;
   localparam logic [4:0] OP_LDI  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SUBI = 5'b00111;
   localparam logic [4:0] OP_AND  = 5'b01000;
   localparam logic [4:0] OP_ANDI = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ORI  = 5'b01011;
   localparam logic [4:0] OP_XOR  = 5'b01100;
   localparam logic [4:0] OP_XORI = 5'b01101;
   localparam logic [4:0] OP_BEQ  = 5'b01110;
   localparam logic [4:0] OP_BNE  = 5'b01111;
   localparam logic [4:0] OP_JMP  = 5'b10000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_MEM   = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      ALU_PASS = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4,
      ALU_XOR  = 3'd5
   } alu_op_t;

   // What the EXEC state has to do with an instruction.
   typedef enum logic [2:0] {
      CL_IMM     = 3'd0,
      CL_MEM_RD  = 3'd1,
      CL_STO     = 3'd2,
      CL_BEQ     = 3'd3,
      CL_BNE     = 3'd4,
      CL_JMP     = 3'd5,
      CL_HLT     = 3'd6,
      CL_ILLEGAL = 3'd7
   } op_class_t;

   function automatic op_class_t op_class(input logic [4:0] opcode);
      case (opcode)
         OP_HLT:                                    return CL_HLT;
         OP_STO:                                    return CL_STO;
         OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                                                    return CL_MEM_RD;
         OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI:
                                                    return CL_IMM;
         OP_BEQ:                                    return CL_BEQ;
         OP_BNE:                                    return CL_BNE;
         OP_JMP:                                    return CL_JMP;
         default:                                   return CL_ILLEGAL;
      endcase
   endfunction

   // Memory and immediate forms of an operation share one ALU op.
   function automatic alu_op_t alu_op_of(input logic [4:0] opcode);
      case (opcode)
         OP_ADD, OP_ADDI: return ALU_ADD;
         OP_SUB, OP_SUBI: return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR,  OP_ORI:  return ALU_OR;
         OP_XOR, OP_XORI: return ALU_XOR;
         default:         return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/bip_alu.sv
// -----------------------------------------------------------------------------
// bip_alu
// Combinational accumulator ALU: result = op(a, b).
// Ports:
//   a       accumulator operand
//   b       memory data or sign-extended immediate
//   alu_op  operation select (pass-b/add/sub/and/or/xor)
//   result  NB_DATA-wide result, add/sub wrap modulo 2^NB_DATA
// -----------------------------------------------------------------------------
module bip_alu
   import bip_pkg::*;
#(
   parameter int NB_DATA = 16
) (
   input  logic [NB_DATA-1:0] a,
   input  logic [NB_DATA-1:0] b,
   input  alu_op_t            alu_op,
   output logic [NB_DATA-1:0] result
);

   always_comb begin
      result = b;
      case (alu_op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         default:  result = b;
      endcase
   end

endmodule

// File: rtl/bip_cpu_mc.sv
// -----------------------------------------------------------------------------
// bip_cpu_mc
// Multicycle BIP CPU: PC, instruction register, FSM and accumulator datapath.
// Talks to a synchronous 1-cycle program ROM and a variable-latency data RAM
// through a request/acknowledge handshake.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_instruc             ROM data (valid one cycle after the PC is driven)
//   i_data_memory         RAM read data, sampled on i_mem_ack
//   i_mem_ack             RAM completes the pending request this cycle
//   o_addr_program_mem    PC
//   o_addr_data_mem       data address from the latched instruction
//   o_data_memory         store data (accumulator)
//   o_WrRam, o_RdRam      registered requests, held until acknowledged
//   o_acc                 accumulator
//   o_halt                CPU halted (leaves only through reset)
//   o_illegal             one-cycle pulse for an undefined opcode
// -----------------------------------------------------------------------------
module bip_cpu_mc
   import bip_pkg::*;
#(
   parameter int NB_INSTRUC = 16,
   parameter int NB_OPCODE  = 5,
   parameter int NB_OPERAND = 11,
   parameter int NB_ADDR    = 11,
   parameter int NB_DATA    = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NB_INSTRUC-1:0] i_instruc,
   input  logic [NB_DATA-1:0]    i_data_memory,
   input  logic                  i_mem_ack,
   output logic [NB_ADDR-1:0]    o_addr_program_mem,
   output logic [NB_ADDR-1:0]    o_addr_data_mem,
   output logic [NB_DATA-1:0]    o_data_memory,
   output logic                  o_WrRam,
   output logic                  o_RdRam,
   output logic [NB_DATA-1:0]    o_acc,
   output logic                  o_halt,
   output logic                  o_illegal
);

   state_t                  state_reg, state_next;
   logic [NB_ADDR-1:0]      pc_reg, pc_next, pc_inc;
   logic [NB_INSTRUC-1:0]   ir_reg, ir_next;
   logic [NB_DATA-1:0]      acc_reg, acc_next;
   logic                    rd_reg, rd_next;
   logic                    wr_reg, wr_next;
   logic                    illegal_reg, illegal_next;

   logic [NB_OPCODE-1:0]    ex_opcode, ir_opcode;
   logic [NB_OPERAND-1:0]   ex_operand, ir_operand;
   logic [4:0]              ex_op5, ir_op5;
   logic [NB_DATA-1:0]      ex_imm;
   logic [NB_ADDR-1:0]      ex_target;
   op_class_t               ex_class;

   alu_op_t                 alu_op;
   logic [NB_DATA-1:0]      alu_b;
   logic [NB_DATA-1:0]      alu_result;

   // EXEC decodes straight from the ROM output; MEM works from the IR copy.
   assign ex_opcode  = i_instruc[NB_INSTRUC-1 -: NB_OPCODE];
   assign ex_operand = i_instruc[NB_OPERAND-1:0];
   assign ir_opcode  = ir_reg[NB_INSTRUC-1 -: NB_OPCODE];
   assign ir_operand = ir_reg[NB_OPERAND-1:0];
   assign ex_op5     = 5'(ex_opcode);
   assign ir_op5     = 5'(ir_opcode);
   assign ex_imm     = NB_DATA'($signed(ex_operand));
   assign ex_target  = ex_operand[NB_ADDR-1:0];
   assign pc_inc     = pc_reg + NB_ADDR'(1);

   // Opcode bits above the 5 defined ones must be zero to be legal.
   assign ex_class = ((ex_opcode >> 5) != '0) ? CL_ILLEGAL : op_class(ex_op5);

   assign alu_op = (state_reg == ST_EXEC) ? alu_op_of(ex_op5) : alu_op_of(ir_op5);
   assign alu_b  = (state_reg == ST_EXEC) ? ex_imm : i_data_memory;

   bip_alu #(
      .NB_DATA (NB_DATA)
   ) u_alu (
      .a      (acc_reg),
      .b      (alu_b),
      .alu_op (alu_op),
      .result (alu_result)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg   <= ST_FETCH;
         pc_reg      <= '0;
         ir_reg      <= '0;
         acc_reg     <= '0;
         rd_reg      <= 1'b0;
         wr_reg      <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         ir_reg      <= ir_next;
         acc_reg     <= acc_next;
         rd_reg      <= rd_next;
         wr_reg      <= wr_next;
         illegal_reg <= illegal_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      ir_next      = ir_reg;
      acc_next     = acc_reg;
      rd_next      = rd_reg;
      wr_next      = wr_reg;
      illegal_next = 1'b0;
      case (state_reg)
         ST_FETCH: state_next = ST_EXEC;
         ST_EXEC: begin
            ir_next    = i_instruc;
            state_next = ST_FETCH;
            case (ex_class)
               CL_IMM: begin
                  acc_next = alu_result;
                  pc_next  = pc_inc;
               end
               CL_MEM_RD: begin
                  rd_next    = 1'b1;
                  state_next = ST_MEM;
               end
               CL_STO: begin
                  wr_next    = 1'b1;
                  state_next = ST_MEM;
               end
               CL_BEQ:  pc_next = (acc_reg == '0) ? ex_target : pc_inc;
               CL_BNE:  pc_next = (acc_reg != '0) ? ex_target : pc_inc;
               CL_JMP:  pc_next = ex_target;
               CL_HLT:  state_next = ST_HALT;
               default: begin
                  illegal_next = 1'b1;
                  pc_next      = pc_inc;
               end
            endcase
         end
         ST_MEM: begin
            // Request and address stay put until the RAM acknowledges.
            if (i_mem_ack) begin
               if (rd_reg) begin
                  acc_next = alu_result;
               end
               pc_next    = pc_inc;
               rd_next    = 1'b0;
               wr_next    = 1'b0;
               state_next = ST_FETCH;
            end
         end
         default: ; // ST_HALT: everything frozen until reset
      endcase
   end

   assign o_addr_program_mem = pc_reg;
   assign o_addr_data_mem    = ir_operand[NB_ADDR-1:0];
   assign o_data_memory      = acc_reg;
   assign o_WrRam            = wr_reg;
   assign o_RdRam            = rd_reg;
   assign o_acc              = acc_reg;
   assign o_halt             = (state_reg == ST_HALT);
   assign o_illegal          = illegal_reg;

endmodule

// File: tb/tb_bip_cpu_mc.sv
// -----------------------------------------------------------------------------
// tb_bip_cpu_mc
// Self-checking bench for bip_cpu_mc: table of single-instruction programs,
// hand-written multicycle sequences and random programs compared against an
// instruction-level interpreter.
// -----------------------------------------------------------------------------
module tb_bip_cpu_mc;

   logic        i_clk;
   logic        i_rst;
   logic [15:0] i_instruc;
   logic [15:0] i_data_memory;
   logic        i_mem_ack;
   logic [10:0] o_addr_program_mem;
   logic [10:0] o_addr_data_mem;
   logic [15:0] o_data_memory;
   logic        o_WrRam;
   logic        o_RdRam;
   logic [15:0] o_acc;
   logic        o_halt;
   logic        o_illegal;

   bip_cpu_mc dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_instruc          (i_instruc),
      .i_data_memory      (i_data_memory),
      .i_mem_ack          (i_mem_ack),
      .o_addr_program_mem (o_addr_program_mem),
      .o_addr_data_mem    (o_addr_data_mem),
      .o_data_memory      (o_data_memory),
      .o_WrRam            (o_WrRam),
      .o_RdRam            (o_RdRam),
      .o_acc              (o_acc),
      .o_halt             (o_halt),
      .o_illegal          (o_illegal)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ---------------- memory models ----------------
   logic [15:0] rom      [0:2047];
   logic [15:0] ram      [0:63];
   logic [15:0] ram_init [0:63];
   logic [15:0] ram_ref  [0:63];

   always @(posedge i_clk) i_instruc <= rom[o_addr_program_mem];

   always @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 64; i++) ram[i] <= ram_init[i];
      end else if (o_WrRam && i_mem_ack) begin
         ram[o_addr_data_mem[5:0]] <= o_data_memory;
      end
   end

   assign i_data_memory = ram[o_addr_data_mem[5:0]];

   // Ack arrives on the lat-th cycle of a request.
   int lat       = 1;
   bit ack_en    = 1'b1;
   bit ack_force = 1'b0;
   int wait_cnt  = 0;
   assign i_mem_ack = ack_force | (ack_en & (o_RdRam | o_WrRam) & (wait_cnt == lat - 1));
   always @(posedge i_clk) begin
      if (!(o_RdRam || o_WrRam) || i_mem_ack) wait_cnt <= 0;
      else                                     wait_cnt <= wait_cnt + 1;
   end

   // ---------------- monitors ----------------
   int          mon_ill     = 0;
   int          mon_wr      = 0;
   int          mon_rd      = 0;
   int          mon_overlap = 0;
   logic [10:0] last_wr_addr;
   logic [15:0] last_wr_data;
   always @(negedge i_clk) begin
      if (o_illegal) mon_ill <= mon_ill + 1;
      if (o_RdRam) mon_rd <= mon_rd + 1;
      if (o_RdRam && o_WrRam) mon_overlap <= mon_overlap + 1;
      if (o_WrRam) begin
         mon_wr       <= mon_wr + 1;
         last_wr_addr <= o_addr_data_mem;
         last_wr_data <= o_data_memory;
      end
   end

   // ---------------- helpers ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
         cyc++;
      end
   endtask

   function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opd);
      return {op, opd};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
      for (int i = 0; i < 64; i++) ram_init[i] = 16'h0000;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick(2);
      i_rst = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_halt(input int max, output int hc);
      while (!o_halt && cyc < max) tick(1);
      hc = cyc;
      if (!o_halt) begin
         errors++;
         $display("FAIL halt_timeout: got no halt after %0d cycles, expected halt", cyc);
      end
   endtask

   // Instruction-level interpreter: one step per instruction, cost counted in
   // cycles (2, or 2 + memory latency for RAM instructions).
   task automatic iss_run(input int lat_v, output logic [15:0] acc_o,
                          output logic [10:0] pc_o, output int cyc_o, output int ill_o);
      logic [15:0] acc, mem, imm;
      logic [10:0] pc, opd;
      logic [4:0]  op;
      bit          done;
      int          steps;
      for (int i = 0; i < 64; i++) ram_ref[i] = ram_init[i];
      pc = 0; acc = 0; cyc_o = 0; ill_o = 0; done = 0; steps = 0;
      while (!done && steps < 1000) begin
         steps++;
         op  = rom[pc][15:11];
         opd = rom[pc][10:0];
         imm = {{5{opd[10]}}, opd};
         mem = ram_ref[opd[5:0]];
         if (op inside {5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12}) cyc_o += 2 + lat_v;
         else cyc_o += 2;
         case (op)
            5'd0:  done = 1;
            5'd1:  ram_ref[opd[5:0]] = acc;
            5'd2:  acc = mem;
            5'd3:  acc = imm;
            5'd4:  acc = acc + mem;
            5'd5:  acc = acc + imm;
            5'd6:  acc = acc - mem;
            5'd7:  acc = acc - imm;
            5'd8:  acc = acc & mem;
            5'd9:  acc = acc & imm;
            5'd10: acc = acc | mem;
            5'd11: acc = acc | imm;
            5'd12: acc = acc ^ mem;
            5'd13: acc = acc ^ imm;
            5'd14, 5'd15, 5'd16: ;
            default: ill_o++;
         endcase
         if ((op == 5'd14 && acc == 0) || (op == 5'd15 && acc != 0) || op == 5'd16) pc = opd;
         else if (!done) pc = pc + 11'd1;
      end
      acc_o = acc;
      pc_o  = pc;
   endtask

   // ---------------- table vectors ----------------
   // Program: LDI a_imm ; <op opd> ; HLT..., RAM[opd] = mval, ack latency 1.
   typedef struct {
      logic [4:0]  op;
      logic [10:0] a_imm;
      logic [10:0] opd;
      logic [15:0] mval;
      logic [15:0] exp_acc;
      logic [10:0] exp_pc;
      int          exp_cyc;
   } vec_t;

   vec_t vecs [16];

   initial begin
      int hc, ill0, wr0, rd0, iss_cyc, iss_ill;
      logic [15:0] iss_acc;
      logic [10:0] iss_pc;
      int bad;

      vecs[0]  = '{5'd4,  11'h3FF, 11'h008, 16'hFC01, 16'h0000, 11'h002, 7}; // ADD wraps
      vecs[1]  = '{5'd6,  11'h005, 11'h008, 16'h0007, 16'hFFFE, 11'h002, 7}; // SUB
      vecs[2]  = '{5'd8,  11'h7F0, 11'h008, 16'h0F3C, 16'h0F30, 11'h002, 7}; // AND
      vecs[3]  = '{5'd10, 11'h00F, 11'h008, 16'hA500, 16'hA50F, 11'h002, 7}; // OR
      vecs[4]  = '{5'd12, 11'h0FF, 11'h008, 16'h0F0F, 16'h0FF0, 11'h002, 7}; // XOR
      vecs[5]  = '{5'd2,  11'h001, 11'h008, 16'hBEEF, 16'hBEEF, 11'h002, 7}; // LD
      vecs[6]  = '{5'd5,  11'h005, 11'h7FE, 16'h0000, 16'h0003, 11'h002, 6}; // ADDI -2
      vecs[7]  = '{5'd11, 11'h100, 11'h400, 16'h0000, 16'hFD00, 11'h002, 6}; // ORI neg
      vecs[8]  = '{5'd7,  11'h000, 11'h001, 16'h0000, 16'hFFFF, 11'h002, 6}; // SUBI
      vecs[9]  = '{5'd14, 11'h000, 11'h00A, 16'h0000, 16'h0000, 11'h00A, 6}; // BEQ taken
      vecs[10] = '{5'd14, 11'h001, 11'h00A, 16'h0000, 16'h0001, 11'h002, 6}; // BEQ not
      vecs[11] = '{5'd15, 11'h7FF, 11'h123, 16'h0000, 16'hFFFF, 11'h123, 6}; // BNE taken
      vecs[12] = '{5'd15, 11'h000, 11'h123, 16'h0000, 16'h0000, 11'h002, 6}; // BNE not
      vecs[13] = '{5'd16, 11'h002, 11'h7FE, 16'h0000, 16'h0002, 11'h7FE, 6}; // JMP
      vecs[14] = '{5'd1,  11'h055, 11'h008, 16'h0000, 16'h0055, 11'h002, 7}; // STO
      vecs[15] = '{5'd17, 11'h003, 11'h008, 16'h0000, 16'h0003, 11'h002, 6}; // illegal

      i_rst = 1'b1;

      // ---- 1: LDI 5; ADDI -2; HLT with ack tied high ----
      clear_mem();
      rom[0] = ins(5'd3, 11'd5);
      rom[1] = ins(5'd5, 11'h7FE);
      ack_force = 1'b1;
      do_reset();
      chk("rst_pc", 32'(o_addr_program_mem), 0);
      chk("rst_acc", 32'(o_acc), 0);
      chk("rst_req", {30'd0, o_RdRam, o_WrRam}, 0);
      chk("rst_halt_ill", {30'd0, o_halt, o_illegal}, 0);
      tick(5);
      chk("t1_halt_c5", 32'(o_halt), 0);
      tick(1);
      chk("t1_halt_c6", 32'(o_halt), 1);
      chk("t1_acc", 32'(o_acc), 3);
      tick(5);
      chk("t1_pc_frozen", 32'(o_addr_program_mem), 2);
      chk("t1_acc_frozen", 32'(o_acc), 3);
      chk("t1_halt_held", 32'(o_halt), 1);
      ack_force = 1'b0;
      $display("test1 LDI/ADDI/HLT acc=0x%0h pc=0x%0h", o_acc, o_addr_program_mem);

      // ---- 2: LDI 7; STO 0x010; LD 0x010 with 3-cycle ack ----
      clear_mem();
      rom[0] = ins(5'd3, 11'd7);
      rom[1] = ins(5'd1, 11'h010);
      rom[2] = ins(5'd2, 11'h010);
      ram_init[16] = 16'h1234;
      lat = 3;
      do_reset();
      wr0 = mon_wr; rd0 = mon_rd;
      tick(4);
      chk("t2_wr_c4", 32'(o_WrRam), 1);
      chk("t2_wr_addr", 32'(o_addr_data_mem), 32'h010);
      chk("t2_wr_data", 32'(o_data_memory), 7);
      tick(2);
      chk("t2_wr_c6", {30'd0, o_WrRam, o_RdRam}, 2);
      tick(1);
      chk("t2_wr_c7", 32'(o_WrRam), 0);
      wait_halt(200, hc);
      chk("t2_cycles", 32'(hc), 14);
      chk("t2_wr_cycles", 32'(mon_wr - wr0), 3);
      chk("t2_rd_cycles", 32'(mon_rd - rd0), 3);
      chk("t2_last_wr", {5'd0, last_wr_addr, last_wr_data}, {5'd0, 11'h010, 16'd7});
      chk("t2_acc", 32'(o_acc), 7);
      chk("t2_ram", 32'(ram[16]), 7);
      $display("test2 STO/LD lat=3 halt_cycle=%0d acc=0x%0h", hc, o_acc);

      // ---- 3: branches and PC wrap ----
      clear_mem();
      lat = 1;
      rom[0] = ins(5'd3, 11'd0);
      rom[1] = ins(5'd14, 11'd5);
      rom[5] = ins(5'd3, 11'd1);
      rom[6] = ins(5'd15, 11'd0);
      do_reset();
      tick(4);
      chk("t3_beq_pc", 32'(o_addr_program_mem), 5);
      tick(4);
      chk("t3_bne_pc", 32'(o_addr_program_mem), 0);
      chk("t3_bne_acc", 32'(o_acc), 1);
      rom[0] = ins(5'd16, 11'h7FF);
      rom[2047] = ins(5'd3, 11'd3);
      do_reset();
      tick(2);
      chk("t3_jmp_pc", 32'(o_addr_program_mem), 32'h7FF);
      tick(2);
      chk("t3_wrap_pc", 32'(o_addr_program_mem), 0);
      chk("t3_wrap_acc", 32'(o_acc), 3);
      $display("test3 branches/wrap pc=0x%0h acc=0x%0h", o_addr_program_mem, o_acc);

      // ---- 4: logic immediates and SUBI underflow ----
      clear_mem();
      rom[0] = ins(5'd3, 11'h0F0);
      rom[1] = ins(5'd13, 11'h0FF);
      rom[2] = ins(5'd9, 11'h00F);
      rom[3] = ins(5'd7, 11'h010);
      do_reset();
      tick(6);
      chk("t4_acc_andi", 32'(o_acc), 32'h000F);
      wait_halt(200, hc);
      chk("t4_cycles", 32'(hc), 10);
      chk("t4_acc_subi", 32'(o_acc), 32'hFFFF);
      $display("test4 logic-imm acc=0x%0h", o_acc);

      // ---- 5: illegal opcode ----
      clear_mem();
      rom[0] = ins(5'd3, 11'd9);
      rom[1] = 16'hF812;
      do_reset();
      ill0 = mon_ill;
      tick(3);
      chk("t5_ill_c3", 32'(o_illegal), 0);
      tick(1);
      chk("t5_ill_c4", 32'(o_illegal), 1);
      chk("t5_pc", 32'(o_addr_program_mem), 2);
      chk("t5_acc", 32'(o_acc), 9);
      tick(1);
      chk("t5_ill_c5", 32'(o_illegal), 0);
      wait_halt(200, hc);
      chk("t5_cycles", 32'(hc), 6);
      chk("t5_pulses", 32'(mon_ill - ill0), 1);
      $display("test5 illegal acc=0x%0h pulses=%0d", o_acc, mon_ill - ill0);

      // ---- 6: reset while waiting for ack ----
      clear_mem();
      rom[0] = ins(5'd3, 11'd5);
      rom[1] = ins(5'd2, 11'h020);
      ram_init[32] = 16'h4242;
      ack_en = 1'b0;
      do_reset();
      tick(4);
      chk("t6_rd_c4", 32'(o_RdRam), 1);
      chk("t6_rd_addr", 32'(o_addr_data_mem), 32'h020);
      tick(3);
      chk("t6_rd_held", 32'(o_RdRam), 1);
      chk("t6_pc_held", 32'(o_addr_program_mem), 1);
      chk("t6_acc_held", 32'(o_acc), 5);
      i_rst = 1'b1;
      tick(1);
      chk("t6_rst_rd", 32'(o_RdRam), 0);
      chk("t6_rst_pc", 32'(o_addr_program_mem), 0);
      chk("t6_rst_acc", 32'(o_acc), 0);
      i_rst = 1'b0;
      cyc = 0;
      tick(3);
      chk("t6_restart_c3", 32'(o_RdRam), 0);
      tick(1);
      chk("t6_restart_c4", 32'(o_RdRam), 1);
      ack_en = 1'b1;
      wait_halt(200, hc);
      chk("t6_cycles", 32'(hc), 7);
      chk("t6_acc", 32'(o_acc), 32'h4242);
      $display("test6 reset-in-MEM acc=0x%0h", o_acc);

      // ---- table vectors ----
      lat = 1;
      for (int v = 0; v < 16; v++) begin
         clear_mem();
         rom[0] = ins(5'd3, vecs[v].a_imm);
         rom[1] = ins(vecs[v].op, vecs[v].opd);
         ram_init[vecs[v].opd[5:0]] = vecs[v].mval;
         do_reset();
         wait_halt(200, hc);
         chk($sformatf("vec%0d_acc", v), 32'(o_acc), 32'(vecs[v].exp_acc));
         chk($sformatf("vec%0d_pc", v), 32'(o_addr_program_mem), 32'(vecs[v].exp_pc));
         chk($sformatf("vec%0d_cycles", v), 32'(hc), 32'(vecs[v].exp_cyc));
         $display("vec %0d op=%0d acc=0x%0h pc=0x%0h cycles=%0d", v, vecs[v].op, o_acc,
                  o_addr_program_mem, hc);
      end

      // ---- random programs vs interpreter ----
      for (int p = 0; p < 20; p++) begin
         int          r;
         logic [4:0]  op;
         logic [10:0] opd;
         clear_mem();
         for (int i = 0; i < 64; i++) ram_init[i] = 16'($urandom);
         for (int i = 0; i < 16; i++) begin
            r = $urandom_range(1, 19);
            if (r >= 17) op = 5'($urandom_range(17, 31));
            else op = 5'(r);
            opd = 11'($urandom);
            if (op inside {5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12}) opd = 11'($urandom_range(0, 63));
            if (op inside {5'd14, 5'd15, 5'd16}) opd = 11'($urandom_range(i + 1, 17));
            rom[i] = ins(op, opd);
         end
         lat = $urandom_range(1, 4);
         iss_run(lat, iss_acc, iss_pc, iss_cyc, iss_ill);
         do_reset();
         ill0 = mon_ill;
         wait_halt(2000, hc);
         chk($sformatf("rnd%0d_acc", p), 32'(o_acc), 32'(iss_acc));
         chk($sformatf("rnd%0d_pc", p), 32'(o_addr_program_mem), 32'(iss_pc));
         chk($sformatf("rnd%0d_cycles", p), 32'(hc), 32'(iss_cyc));
         chk($sformatf("rnd%0d_illegal", p), 32'(mon_ill - ill0), 32'(iss_ill));
         bad = 0;
         for (int i = 0; i < 64; i++) if (ram[i] !== ram_ref[i]) bad++;
         chk($sformatf("rnd%0d_ram_bad_words", p), 32'(bad), 0);
         $display("rnd %0d lat=%0d acc=0x%0h pc=0x%0h cycles=%0d illegal=%0d", p, lat, o_acc,
                  o_addr_program_mem, hc, mon_ill - ill0);
      end

      chk("rd_wr_overlap", 32'(mon_overlap), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish by time limit, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bip_cpu_mc.md
Name: bip_cpu_mc

Overview:
Parametrised multicycle successor of the BIP-I CPU top. It integrates control (PC, instruction register, FSM) and datapath (accumulator, ALU) in one block. Adds a data-memory request/acknowledge handshake for variable-latency RAM, BIP-II logic ops, branches, halt and illegal-opcode reporting. It sits between a synchronous 1-cycle program ROM and a data RAM.

Parameters:
NB_INSTRUC, 16, instruction width (NB_OPCODE + NB_OPERAND)
NB_OPCODE, 5, opcode field width (instruction MSBs)
NB_OPERAND, 11, operand/immediate field width (instruction LSBs)
NB_ADDR, 11, program and data address width; must be <= NB_OPERAND
NB_DATA, 16, accumulator/data width; must be >= NB_OPERAND

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_instruc  in  NB_INSTRUC  program ROM data, valid 1 cycle after o_addr_program_mem
i_data_memory  in  NB_DATA  RAM read data, valid when i_mem_ack=1 during a read
i_mem_ack  in  1  RAM completes current read/write this cycle
o_addr_program_mem  out  NB_ADDR  PC
o_addr_data_mem  out  NB_ADDR  operand[NB_ADDR-1:0] of latched instruction
o_data_memory  out  NB_DATA  store data (= ACC)
o_WrRam  out  1  write request, held until ack
o_RdRam  out  1  read request, held until ack
o_acc  out  NB_DATA  accumulator
o_halt  out  1  CPU halted
o_illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset (sync, i_rst=1 at edge): PC=0, ACC=0, IR=0, state=FETCH; o_WrRam=o_RdRam=o_halt=o_illegal=0. Reset mid-MEM drops the request at that edge, no ACC/PC update.
- Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI, 01000 AND, 01001 ANDI, 01010 OR, 01011 ORI, 01100 XOR, 01101 XORI, 01110 BEQ, 01111 BNE, 10000 JMP; all others illegal.
- Immediates sign-extended from NB_OPERAND to NB_DATA. ADD/SUB modulo 2^NB_DATA, no flags stored.
- FSM states FETCH, EXEC, MEM, HALT:
  - FETCH: drive PC; next EXEC.
  - EXEC: IR <= i_instruc; decode i_instruc.
    - Immediate/logic-immediate ops: ACC updated, PC+1, go FETCH.
    - LD/ADD/SUB/AND/OR/XOR: go MEM, o_RdRam=1 from next cycle.
    - STO: go MEM, o_WrRam=1, o_data_memory=ACC.
    - BEQ: PC=operand if ACC==0, else PC+1. BNE: inverse. JMP: PC=operand[NB_ADDR-1:0]. Next FETCH.
    - HLT: go HALT.
    - Illegal: o_illegal=1 next cycle, PC+1, go FETCH.
  - MEM: request and address held stable. When i_mem_ack=1, ACC <= op(ACC, i_data_memory) for reads (none for STO), PC+1, request deasserted next cycle, go FETCH. No timeout.
  - HALT: o_halt=1; PC, ACC frozen; exit only by reset.
- Latency: non-memory instruction 2 cycles; memory instruction 2 + k cycles, k>=1 = MEM cycles up to and including ack.
- PC increment wraps 2^NB_ADDR-1 -> 0.
- o_RdRam and o_WrRam never both 1. Both are registered; o_addr_data_mem is driven from IR.
- i_mem_ack outside MEM is ignored.

Decomposition:
- Package bip_pkg: opcode localparams, FSM state encoding, and the ALU-op encoding.
- One sub-module bip_alu: combinational op(a, b, aluop) -> NB_DATA result, covering pass-b/add/sub/and/or/xor.
- FSM, PC, IR and ACC stay in bip_cpu_mc.

Test Plan:
1. Program LDI 5; ADDI -2; HLT, with ack tied 1 -> ACC=3, o_halt=1 at cycle 6, PC frozen at 2.
2. LDI 7; STO 0x010; LD 0x010 with ack delayed 3 cycles -> o_WrRam held 3 cycles with addr 0x010 and data 7, ACC=7, each mem instruction takes 5 cycles.
3. LDI 0; BEQ 0x005 -> PC=5. Then LDI 1; BNE 0x000 -> PC=0. Then JMP 0x7FF; JMP falls through -> PC wraps 0x7FF -> 0x000.
4. LDI 0x0F0; XORI 0x0FF; ANDI 0x00F -> ACC=0x000F. Then SUBI 0x010 -> ACC=0xFFFF.
5. Opcode 11111 -> o_illegal pulses 1 cycle, ACC unchanged, PC+1.
6. Assert i_rst while in MEM with ack=0 -> next cycle o_RdRam=0, PC=0, ACC=0, state FETCH.
